// File: rtl/dsp_pkg.sv
// dsp_pkg: shared state codes, config bit indices and stage ordering for the DSP sequencer
package dsp_pkg;
   localparam int TIMEOUT_DEFAULT = 4096;
   localparam int FIR_BIT  = 0;
   localparam int FFT_BIT  = 1;
   localparam int IFFT_BIT = 2;
   localparam int DMA_BIT  = 3;
   localparam int CONT_BIT = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FIR_RUN  = 3'd1,
      FFT_RUN  = 3'd2,
      IFFT_RUN = 3'd3,
      STORE    = 3'd4,
      DMA_RUN  = 3'd5,
      DONE     = 3'd6,
      ERROR    = 3'd7
   } state_t;

   // First enabled stage after cur; IDLE/DONE start from the top of the chain.
   // STORE is only reachable via FFT/IFFT, so it needs no separate enable test.
   function automatic state_t next_stage(state_t cur, logic [4:0] cfg);
      state_t after_store, after_fir;
      after_store = cfg[DMA_BIT] ? DMA_RUN : DONE;
      after_fir   = cfg[FFT_BIT] ? FFT_RUN : cfg[IFFT_BIT] ? IFFT_RUN : after_store;
      case (cur)
         IDLE, DONE: return cfg[FIR_BIT] ? FIR_RUN : after_fir;
         FIR_RUN:    return after_fir;
         FFT_RUN:    return cfg[IFFT_BIT] ? IFFT_RUN : STORE;
         IFFT_RUN:   return STORE;
         STORE:      return after_store;
         default:    return DONE;
      endcase
   endfunction
endpackage

// File: rtl/stage_timer.sv
// stage_timer: per-stage wait counter, cleared on state entry, flags the entry cycle and expiry
module stage_timer #(
   parameter int LIMIT = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired,
   output logic first
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt;

   // Count cycles spent in the current stage; stop at the limit so it never wraps
   always_ff @(posedge clk) begin
      if (!reset || clear) cnt <= '0;
      else if (enable && !expired) cnt <= cnt + W'(1);
   end

   assign expired = cnt == W'(LIMIT);
   assign first   = cnt == '0;
endmodule

// File: rtl/dsp_sequencer.sv
// dsp_sequencer: walks a block through the enabled FIR/FFT/IFFT/STORE/DMA stages with timeouts
module dsp_sequencer
   import dsp_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ready_for_processing,
   input  logic [4:0]       config_mode,
   input  logic             fir_done,
   input  logic             fft_done,
   input  logic             ifft_done,
   input  logic             dma_done,
   input  logic             buffer_ready,
   input  logic             clear_error,
   output logic             start_fir,
   output logic             start_fft,
   output logic             start_ifft,
   output logic             start_dma_out,
   output logic             store_out,
   output logic             busy,
   output logic [2:0]       stage,
   output logic             block_done,
   output logic             error,
   output logic [CNT_W-1:0] block_count
);
   state_t     state, nxt;
   logic [4:0] cfg_q;
   logic       done_sel, expired, first, latch, run;

   assign run = state inside {FIR_RUN, FFT_RUN, IFFT_RUN, STORE, DMA_RUN};

   stage_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (nxt != state),
      .enable  (run),
      .expired (expired),
      .first   (first)
   );

   // Pick the completion input that belongs to the current stage; all others are ignored
   always_comb begin
      done_sel = state == FIR_RUN  ? fir_done  :
                 state == FFT_RUN  ? fft_done  :
                 state == IFFT_RUN ? ifft_done :
                 state == STORE    ? buffer_ready :
                 state == DMA_RUN  ? dma_done  : 1'b0;
   end

   // Next state and config latch; a done in the same cycle as expiry still advances
   always_comb begin
      nxt   = state;
      latch = 1'b0;
      case (state)
         IDLE: begin
            latch = ready_for_processing;
            if (ready_for_processing) nxt = next_stage(IDLE, config_mode);
         end
         DONE: begin
            latch = cfg_q[CONT_BIT] && ready_for_processing;
            nxt   = latch ? next_stage(DONE, config_mode) : IDLE;
         end
         ERROR: nxt = clear_error ? IDLE : ERROR;
         default: nxt = (done_sel && !first) ? next_stage(state, cfg_q) : expired ? ERROR : state;
      endcase
   end

   // Decode outputs from the state; pulses only in the entry cycle of their stage
   always_comb begin
      start_fir     = state == FIR_RUN  && first;
      start_fft     = state == FFT_RUN  && first;
      start_ifft    = state == IFFT_RUN && first;
      store_out     = state == STORE    && first;
      start_dma_out = state == DMA_RUN  && first;
      busy          = state != IDLE && state != ERROR;
      block_done    = state == DONE;
      error         = state == ERROR;
      stage         = state;
   end

   // State, latched configuration and completed-block counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         cfg_q       <= '0;
         block_count <= '0;
      end else begin
         state <= nxt;
         if (latch) cfg_q <= config_mode;
         if (state == DONE) block_count <= block_count + CNT_W'(1);
      end
   end
endmodule

// File: doc/dsp_sequencer.md
DSP_SEQUENCER -- requirements
Module: dsp_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum wait cycles per stage before error.
REQ-002 SHALL have parameter CNT_W, default 16: block_count width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 ready_for_processing  input  1  level; input buffer holds a full block.
REQ-006 config_mode  input  5  bit0 FIR en, bit1 FFT en, bit2 IFFT en, bit3 DMA en, bit4 continuous.
REQ-007 fir_done, fft_done, ifft_done, dma_done  input  1 each  completion pulses from the engines.
REQ-008 buffer_ready  input  1  output buffer has captured the result.
REQ-009 clear_error  input  1  pulse; leaves ERROR.
REQ-010 start_fir, start_fft, start_ifft, start_dma_out  output  1 each  single-cycle start pulses.
REQ-011 store_out  output  1  single-cycle store strobe to the output buffer.
REQ-012 busy  output  1  high in every state except IDLE and ERROR.
REQ-013 stage  output  3  current state code.
REQ-014 block_done  output  1  single-cycle pulse per completed block.
REQ-015 error  output  1  high while in ERROR.
REQ-016 block_count  output  CNT_W  completed blocks, wraps at 2^CNT_W-1 -> 0.

Function
REQ-017 States and codes: IDLE=0, FIR_RUN=1, FFT_RUN=2, IFFT_RUN=3, STORE=4, DMA_RUN=5, DONE=6, ERROR=7.
REQ-018 In IDLE with ready_for_processing=1: config_mode is latched into cfg_q, and the FSM moves to the first enabled stage in the order FIR, FFT, IFFT, STORE, DMA.
REQ-019 STORE is enabled when cfg_q FFT or IFFT is set.
REQ-020 If cfg_q[3:0]=0, the FSM goes from IDLE directly to DONE.
REQ-021 config_mode changes while busy SHALL have no effect until the next IDLE/DONE latch.
REQ-022 Each run state asserts its start pulse for exactly the first cycle after entry; STORE asserts store_out the same way.
REQ-023 The matching done input (buffer_ready for STORE) SHALL be ignored in the entry cycle; from the second cycle on, done=1 advances to the next enabled stage, or to DONE.
REQ-024 Done inputs not matching the current state SHALL be ignored in all states.
REQ-025 Timeout counter clears on state entry and increments each wait cycle; reaching TIMEOUT_CYCLES without done enters ERROR.
REQ-026 If done and timeout coincide, done wins.
REQ-027 DONE lasts one cycle: block_done=1 and block_count+1.
REQ-028 From DONE: if cfg_q bit4=1 and ready_for_processing=1, re-latch config_mode and go to the first enabled stage; otherwise go to IDLE.
REQ-029 ERROR holds with all start pulses low until clear_error=1, then goes to IDLE; block_count is unchanged.
REQ-030 Latency: IDLE->start_fir is 1 cycle after ready_for_processing is sampled high; done->next start is 1 cycle.

Reset
REQ-031 With reset=0 at a clock edge, the block SHALL reset: state=IDLE, cfg_q=0, timeout counter=0, block_count=0, all pulses/busy/error=0, stage=0.
REQ-032 Reset mid-operation SHALL abandon the block with no block_done and no further start pulses.

Structure
REQ-033 State codes, config_mode bit indices and the TIMEOUT_CYCLES default SHALL live in shared package dsp_pkg.
REQ-034 The timeout counter SHALL be a sub-module stage_timer (clear, enable, expired).
REQ-035 Next-stage selection SHALL be a single combinational function of current state and cfg_q.

Verification
REQ-036 config_mode=5'b01111, ready=1, each done 10 cycles after its start -> start order fir, fft, ifft, store_out, dma; one block_done; block_count=1.
REQ-037 config_mode=5'b01001 -> only start_fir and start_dma_out fire; store_out is never asserted; stage sequence 0,1,5,6,0.
REQ-038 TIMEOUT_CYCLES=8, fft_done withheld -> ERROR after 8 wait cycles, error=1; clear_error -> IDLE; block_count unchanged.
REQ-039 config_mode=5'b11111, ready held high, three blocks -> back-to-back runs with no IDLE visit; block_count=3.
REQ-040 fir_done pulsed in the FIR_RUN entry cycle and in FFT_RUN -> both ignored; reset=0 during DMA_RUN -> all outputs 0 in the next cycle and no block_done.
